// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared types and default 640x480@60 timing for the VGA generator
package vga_timing_pkg;

  localparam int COORD_W = 13;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } tim_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_sync_axis.sv
// rtl/vga_sync_axis.sv - one timing axis: wrap counter plus active/sync region decode
module vga_sync_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t count,
  output logic   wrap,
  output logic   active,
  output logic   sync
);

  localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END    = coord_t'(ACTIVE);
  localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

  assign wrap   = advance && (count == LAST);
  assign active = (count < ACT_END);
  assign sync   = (count >= SYNC_START) && (count < SYNC_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (advance) begin
      if (count == LAST) count <= '0;
      else               count <= count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator with pixel fetch and 2-stage output pipeline
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic        pix_req,
  output coord_t      pix_req_x,
  output coord_t      pix_req_y,
  input  logic [23:0] pix_data,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output coord_t      x_count,
  output coord_t      y_count,
  output logic        frame_start
);

  coord_t h, v, x1, y1;
  logic   h_wrap, h_act, h_sync, v_act, v_sync, unused_v_wrap;
  tim_t   tim0, tim1;
  logic   first1;

  vga_sync_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .clk(clk), .reset(reset), .advance(ce),
    .count(h), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );

  // The vertical axis steps once per completed line.
  vga_sync_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .clk(clk), .reset(reset), .advance(h_wrap),
    .count(v), .wrap(unused_v_wrap), .active(v_act), .sync(v_sync)
  );

  assign tim0      = '{hs: h_sync, vs: v_sync, active: h_act & v_act};
  assign pix_req   = tim0.active;
  assign pix_req_x = h;
  assign pix_req_y = v;

  always_ff @(posedge clk) begin
    if (reset) begin
      tim1   <= '0;
      x1     <= '0;
      y1     <= '0;
      first1 <= 1'b0;
    end else if (ce) begin
      tim1   <= tim0;
      x1     <= h;
      y1     <= v;
      first1 <= (h == '0) && (v == '0);
    end
  end

  // pix_data answers the request made one enabled cycle earlier, now held in stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      x_count      <= '0;
      y_count      <= '0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= ce & first1;
      if (ce) begin
        oVGA_HS      <= ~tim1.hs;
        oVGA_VS      <= ~tim1.vs;
        oVGA_BLANK_N <= tim1.active;
        oVGA_R       <= tim1.active ? pix_data[23:16] : 8'd0;
        oVGA_G       <= tim1.active ? pix_data[15:8]  : 8'd0;
        oVGA_B       <= tim1.active ? pix_data[7:0]   : 8'd0;
        x_count      <= x1;
        y_count      <= y1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen with small 8x6 timing
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        pix_req;
  logic [12:0] pix_req_x, pix_req_y, x_count, y_count;
  logic [23:0] pix_data;
  logic        hs, vs, blank_n, frame_start;
  logic [7:0]  r, g, b;

  typedef struct {
    logic        req;
    logic [12:0] rx, ry;
    logic        hs, vs, bn;
    logic [7:0]  r, g, b;
    logic [12:0] xc, yc;
    logic        fs;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   n = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .pix_req(pix_req), .pix_req_x(pix_req_x), .pix_req_y(pix_req_y),
    .pix_data(pix_data),
    .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_N(blank_n),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
    .x_count(x_count), .y_count(y_count), .frame_start(frame_start)
  );

  // Pixel source: answers a request one enabled cycle later; junk when nothing was asked.
  logic        src_valid = 1'b0;
  logic [12:0] src_x = '0, src_y = '0;
  always @(posedge clk) begin
    if (ce) begin
      src_valid <= pix_req;
      src_x     <= pix_req_x;
      src_y     <= pix_req_y;
    end
  end
  assign pix_data = src_valid ? {src_y[7:0], src_x[7:0], 8'hA5} : 24'h5A5A5A;

  // n = enabled edges since reset; outputs show the pixel two enabled cycles back.
  function automatic exp_t model(int cnt, bit fs_ok);
    exp_t e;
    int h, v, p, ph, pv;
    bit act;
    h = cnt % 8;
    v = (cnt / 8) % 6;
    e.req = (h < 4) && (v < 3);
    e.rx  = 13'(h);
    e.ry  = 13'(v);
    p = cnt - 2;
    if (p < 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
      e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
      e.xc = '0; e.yc = '0; e.fs = 1'b0;
    end else begin
      ph  = p % 8;
      pv  = (p / 8) % 6;
      act = (ph < 4) && (pv < 3);
      e.hs = !(ph == 5 || ph == 6);
      e.vs = !(pv == 4);
      e.bn = act;
      e.r  = act ? 8'(pv) : 8'd0;
      e.g  = act ? 8'(ph) : 8'd0;
      e.b  = act ? 8'hA5 : 8'd0;
      e.xc = 13'(ph);
      e.yc = 13'(pv);
      e.fs = fs_ok && (ph == 0) && (pv == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s at n=%0d t=%0t: got %0h want %0h", name, n, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin : mon
      exp_t e;
      e = q.pop_front();
      chk("pix_req",     pix_req,     e.req);
      chk("pix_req_x",   pix_req_x,   e.rx);
      chk("pix_req_y",   pix_req_y,   e.ry);
      chk("hs",          hs,          e.hs);
      chk("vs",          vs,          e.vs);
      chk("blank_n",     blank_n,     e.bn);
      chk("r",           r,           e.r);
      chk("g",           g,           e.g);
      chk("b",           b,           e.b);
      chk("x_count",     x_count,     e.xc);
      chk("y_count",     y_count,     e.yc);
      chk("frame_start", frame_start, e.fs);
    end
  end

  task automatic step(input bit c, input bit rst);
    ce    = c;
    reset = rst;
    @(posedge clk);
    if (rst)    n = 0;
    else if (c) n++;
    q.push_back(model(n, c && !rst));
    #2;
  endtask

  initial begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 110; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) step(i % 3 == 0, 1'b0);
    for (int i = 0; i < 60 && (n % 48) != 19; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
